asym_pingpong_ram: RTL and testbench

- Double-buffered asymmetric RAM for the matrix-multiply datapath. It is the successor to the single-bank narrow-write/wide-read RAM.
- Narrow write stream: one DATA_WIDTH lane per beat. Lanes are packed into DATA_RATIO-lane rows and stored in one of two banks.
- When a bank closes, the wide read stream drains it row by row. The write side fills the other bank at the same time.
- Sits between the operand loader (narrow side) and the MAC array row feeder (wide side).

---
 rtl/asym_pingpong_ram.sv | 205 ++++++++++++++++++++
 tb/tb_asym_pingpong_ram.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_pingpong_ram.sv
// Double-buffered narrow-write / wide-read RAM.
// The write side packs DATA_WIDTH lanes into DATA_RATIO-lane rows and stores
// them in the current write bank. When that bank closes, the read side drains
// it row by row through a 2-entry skid buffer. Meanwhile the write side fills
// the other bank.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   wr_valid/wr_ready      narrow lane handshake (wr_ready = !bank_full[wbank])
//   wr_data, wr_last       lane payload; wr_last closes the bank after this lane
//   rd_valid/rd_ready      wide row handshake
//   rd_data, rd_last       wide row (lane 0 in LSBs); rd_last marks a bank's final row
//   bank_full              per-bank "closed, awaiting or under drain" flags
module asym_pingpong_ram #(
  parameter int unsigned DATA_RATIO = 8,
  parameter int unsigned ADDR_DEPTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             wr_last,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [DATA_RATIO*DATA_WIDTH-1:0] rd_data,
  output logic                             rd_last,
  output logic [1:0]                       bank_full
);

  localparam int unsigned ROW_AW    = $clog2(ADDR_DEPTH);
  localparam int unsigned LANE_AW   = $clog2(DATA_RATIO);
  localparam int unsigned ROW_W     = DATA_RATIO * DATA_WIDTH;
  localparam int unsigned MEM_DEPTH = 2 * (1 << ROW_AW);

  // Write-side state
  logic               wbank;
  logic [LANE_AW-1:0] lane;
  logic [ROW_AW-1:0]  wrow;
  logic [ROW_W-1:0]   pack;
  logic [ROW_AW-1:0]  last_row [2];

  // Read-issue state: ibank/irow may run ahead of rbank into the next bank
  logic               rbank;
  logic               ibank;
  logic [ROW_AW-1:0]  irow;
  logic [1:0]         issued;

  // RAM and output pipeline
  logic [ROW_W-1:0]   mem [MEM_DEPTH];
  logic [ROW_W-1:0]   ram_q;
  logic               ram_v;
  logic               ram_last;
  logic [ROW_W-1:0]   skid_data;
  logic               skid_v;
  logic               skid_last;

  // Combinational next-state terms
  logic               wr_acc;
  logic               commit;
  logic               close;
  logic [ROW_W-1:0]   commit_row;
  logic               pop;
  logic               drain_done;
  logic [1:0]         occ;
  logic               issue;
  logic               issue_last;
  logic [1:0]         bank_full_n;
  logic [1:0]         issued_n;
  logic               out_v_n;
  logic [ROW_W-1:0]   out_d_n;
  logic               out_l_n;
  logic               sk_v_n;
  logic [ROW_W-1:0]   sk_d_n;
  logic               sk_l_n;

  assign wr_ready   = !bank_full[wbank];
  assign wr_acc     = wr_valid && wr_ready;
  assign commit     = wr_acc && ((lane == LANE_AW'(DATA_RATIO - 1)) || wr_last);
  // wr_last on the final lane of the final row is still a single close
  assign close      = commit && ((wrow == ROW_AW'(ADDR_DEPTH - 1)) || wr_last);
  assign pop        = rd_valid && rd_ready;
  assign drain_done = pop && rd_last;

  // Items held or in flight; a read may issue only if it will have a slot
  assign occ        = 2'(rd_valid) + 2'(skid_v) + 2'(ram_v);
  assign issue      = bank_full[ibank] && !issued[ibank] &&
                      ((occ < 2'd2) || ((occ == 2'd2) && pop));
  assign issue_last = (irow == last_row[ibank]);

  // Pack register with the incoming lane merged in
  always_comb begin
    commit_row = pack;
    for (int i = 0; i < int'(DATA_RATIO); i++) begin
      if (lane == LANE_AW'(i)) commit_row[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
    end
  end

  // Bank flags: writer closes wbank, reader frees rbank; they never coincide
  always_comb begin
    bank_full_n = bank_full;
    issued_n    = issued;
    if (close)               bank_full_n[wbank] = 1'b1;
    if (drain_done)          bank_full_n[rbank] = 1'b0;
    if (issue && issue_last) issued_n[ibank]    = 1'b1;
    if (drain_done)          issued_n[rbank]    = 1'b0;
  end

  // Output register + skid entry, filled in order from the RAM stage
  always_comb begin
    out_v_n = rd_valid;
    out_d_n = rd_data;
    out_l_n = rd_last;
    sk_v_n  = skid_v;
    sk_d_n  = skid_data;
    sk_l_n  = skid_last;
    if (pop || !rd_valid) begin
      if (skid_v) begin
        out_v_n = 1'b1;
        out_d_n = skid_data;
        out_l_n = skid_last;
        sk_v_n  = ram_v;
        sk_d_n  = ram_q;
        sk_l_n  = ram_v && ram_last;
      end else begin
        out_v_n = ram_v;
        out_d_n = ram_q;
        out_l_n = ram_v && ram_last;
        sk_v_n  = 1'b0;
      end
    end else if (ram_v) begin
      sk_v_n = 1'b1;
      sk_d_n = ram_q;
      sk_l_n = ram_last;
    end
  end

  // Row storage, address {bank,row}; contents are not reset
  always_ff @(posedge clk) begin
    if (rst_n && commit) mem[{wbank, wrow}] <= commit_row;
    if (issue)           ram_q <= mem[{ibank, irow}];
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbank       <= 1'b0;
      lane        <= '0;
      wrow        <= '0;
      pack        <= '0;
      last_row[0] <= '0;
      last_row[1] <= '0;
      rbank       <= 1'b0;
      ibank       <= 1'b0;
      irow        <= '0;
      issued      <= 2'b00;
      bank_full   <= 2'b00;
      ram_v       <= 1'b0;
      ram_last    <= 1'b0;
      skid_v      <= 1'b0;
      skid_last   <= 1'b0;
      skid_data   <= '0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_data     <= '0;
    end else begin
      if (wr_acc) begin
        if (commit) begin
          pack <= '0;
          lane <= '0;
          if (close) begin
            last_row[wbank] <= wrow;
            wbank           <= ~wbank;
            wrow            <= '0;
          end else begin
            wrow <= wrow + ROW_AW'(1);
          end
        end else begin
          pack <= commit_row;
          lane <= lane + LANE_AW'(1);
        end
      end
      if (issue) begin
        if (issue_last) begin
          irow  <= '0;
          ibank <= ~ibank;
        end else begin
          irow <= irow + ROW_AW'(1);
        end
      end
      if (drain_done) rbank <= ~rbank;
      bank_full <= bank_full_n;
      issued    <= issued_n;
      ram_v     <= issue;
      ram_last  <= issue_last;
      skid_v    <= sk_v_n;
      skid_data <= sk_d_n;
      skid_last <= sk_l_n;
      rd_valid  <= out_v_n;
      rd_data   <= out_d_n;
      rd_last   <= out_l_n;
    end
  end

endmodule

// File: tb/tb_asym_pingpong_ram.sv
// Bench for asym_pingpong_ram (DATA_RATIO=4, ADDR_DEPTH=4, DATA_WIDTH=8).
// The reference model tracks expected rows as a queue built from lane
// packing rules, plus a count of closed-but-undrained banks.
module tb_asym_pingpong_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic [1:0]  bank_full;

  asym_pingpong_ram #(.DATA_RATIO(4), .ADDR_DEPTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model
  logic [31:0] q_data [$];
  logic        q_last [$];
  logic [31:0] pend   [$];
  logic [31:0] cur_row;
  int          cur_lane;
  int          cur_rows;
  int          full_count;
  int          delivered;
  int          accepts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q_data.delete(); q_last.delete(); pend.delete();
    cur_row = '0; cur_lane = 0; cur_rows = 0; full_count = 0;
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
    cur_row[cur_lane*8 +: 8] = d;
    cur_lane++;
    accepts++;
    if (cur_lane == 4 || l) begin
      pend.push_back(cur_row);
      cur_row = '0; cur_lane = 0; cur_rows++;
      if (cur_rows == 4 || l) begin
        for (int i = 0; i < pend.size(); i++) begin
          q_data.push_back(pend[i]);
          q_last.push_back(i == pend.size() - 1);
        end
        pend.delete();
        cur_rows = 0;
        full_count++;
      end
    end
  endtask

  // One clock: check presented outputs, drive inputs, advance model past the edge
  task automatic step(input logic wv, input logic [7:0] wd, input logic wl, input logic rr);
    logic acc, pop, lst;
    wr_valid = wv; wr_data = wd; wr_last = wl; rd_ready = rr;
    chk("wr_ready", 32'(wr_ready), 32'(full_count < 2));
    chk("bank_full_count", 32'($countones(bank_full)), 32'(full_count));
    if (rd_valid) begin
      if (q_data.size() == 0) chk("spurious_row", 32'(rd_valid), 32'd0);
      else begin
        chk("rd_data", rd_data, q_data[0]);
        chk("rd_last", 32'(rd_last), 32'(q_last[0]));
      end
    end
    acc = wv && wr_ready;
    pop = rd_valid && rr && (q_data.size() != 0);
    @(posedge clk); #1;
    if (pop) begin
      lst = q_last.pop_front();
      void'(q_data.pop_front());
      delivered++;
      if (lst) full_count--;
    end
    if (acc) model_accept(wd, wl);
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q_data.size() == 0 && !rd_valid) break;
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("drain_done", 32'(q_data.size() == 0 && !rd_valid), 32'd1);
    chk("drain_bank_full", 32'(bank_full), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rd_valid) break;
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("wait_valid", 32'(rd_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic pat [6];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
    wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; rd_ready = 1'b0;
    delivered = 0; accepts = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_bank_full", 32'(bank_full), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);

    // Full bank, no backpressure
    delivered = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    chk("full_lat_e0", 32'(rd_valid), 32'd0);
    chk("full_bf_closed", 32'(bank_full), 32'b01);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("full_lat_e1", 32'(rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("full_lat_e2", 32'(rd_valid), 32'd1);
    chk("full_row0", rd_data, 32'h03020100);
    chk("full_row0_last", 32'(rd_last), 32'd0);
    drain(20);
    chk("full_rows", 32'(delivered), 32'd4);

    // Partial close
    delivered = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA1 + i), 1'(i == 4), 1'b0);
    wait_valid(10);
    chk("part_row0", rd_data, 32'hA4A3A2A1);
    drain(20);
    chk("part_rows", 32'(delivered), 32'd2);

    // Ping-pong overlap with reader stalled
    delivered = 0; accepts = 0;
    for (int i = 0; i < 32; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("pp_accepts", 32'(accepts), 32'd32);
    chk("pp_wr_ready", 32'(wr_ready), 32'd0);
    chk("pp_bank_full", 32'(bank_full), 32'b11);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("pp_stall_accepts", 32'(accepts), 32'd32);
    chk("pp_stall_bf", 32'(bank_full), 32'b11);
    for (int i = 0; i < 20; i++) begin
      if (rd_valid && rd_last) begin
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("pp_free_wr_ready", 32'(wr_ready), 32'd1);
        chk("pp_free_bf", 32'(bank_full), 32'b10);
        break;
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("pp_first_half", 32'(delivered), 32'd4);
    drain(20);
    chk("pp_rows", 32'(delivered), 32'd8);

    // Backpressure pattern during a drain
    delivered = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (q_data.size() == 0 && !rd_valid) break;
      step(1'b0, 8'h00, 1'b0, pat[i % 6]);
    end
    drain(10);
    chk("bp_rows", 32'(delivered), 32'd4);

    // Reset while row 1 is presented
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    wait_valid(10);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rm_row1", rd_data, 32'h07060504);
    do_reset();
    chk("rm_rd_valid", 32'(rd_valid), 32'd0);
    chk("rm_bank_full", 32'(bank_full), 32'd0);
    chk("rm_wr_ready", 32'(wr_ready), 32'd1);
    delivered = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 + i), 1'(i == 3), 1'b0);
    chk("rm_bf_bank0", 32'(bank_full), 32'b01);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rm_fresh_valid", 32'(rd_valid), 32'd1);
    chk("rm_fresh_row", rd_data, 32'h14131211);
    chk("rm_fresh_last", 32'(rd_last), 32'd1);
    drain(10);
    chk("rm_rows", 32'(delivered), 32'd1);

    // Close of bank 1 on the same edge as the final handshake of bank 0
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hB1 + i), 1'(i == 3), 1'b0);
    wait_valid(10);
    chk("col_b0_last", 32'(rd_last), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
    step(1'b1, 8'h24, 1'b1, 1'b1);
    chk("col_bank_full", 32'(bank_full), 32'b10);
    chk("col_wbank", 32'(dut.wbank), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("col_e1_valid", 32'(rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("col_e2_valid", 32'(rd_valid), 32'd1);
    chk("col_e2_row", rd_data, 32'h24232221);
    drain(10);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 9) < 7));
    drain(60);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute time bound
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
